// File: rtl/regfile_writeback_pkg.sv
// Shared types and widths for the register-file writeback master.
package wb_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_A    = 2'd1,
        WB_SRC_B    = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, register-file write port and forwarding lookups.
interface regfile_writeback_if;
    import wb_pkg::*;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [XLEN-1:0]   a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [XLEN-1:0]   b_data;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic [ADDR_W-1:0] q1_addr;
    logic [ADDR_W-1:0] q2_addr;
    logic              q1_hit;
    logic              q2_hit;
    logic [XLEN-1:0]   q1_data;
    logic [XLEN-1:0]   q2_data;

    // Writeback block side
    modport master (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  q1_addr, q2_addr,
        output a_ready, b_ready,
        output wb_we, wb_addr, wb_data,
        output q1_hit, q2_hit, q1_data, q2_data
    );

    // Producers, decode and register-file side
    modport slave (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output q1_addr, q2_addr,
        input  a_ready, b_ready,
        input  wb_we, wb_addr, wb_data,
        input  q1_hit, q2_hit, q1_data, q2_data
    );

endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Two-way arbiter: A has priority, B is forced through after STARVE_MAX consecutive losses.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic       b_valid,
    output logic [1:0] grant_c,
    output wb_src_e    src_c
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Grant selection and starvation tracking
    always_comb begin
        grant_c      = 2'b00;
        src_c        = WB_SRC_NONE;
        starve_cnt_d = starve_cnt_q;
        force_b      = (starve_cnt_q == STARVE_LIM);

        if (a_valid && !(b_valid && force_b)) begin
            grant_c = 2'b01;
            src_c   = WB_SRC_A;
        end else if (b_valid) begin
            grant_c = 2'b10;
            src_c   = WB_SRC_B;
        end

        if (!b_valid || grant_c[1]) begin
            starve_cnt_d = '0;
        end else if (!force_b) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback master: arbitrates two producers into one registered write port with forwarding.
// Optional WB_X0_FILTER_EN: accepted writes to x0 are dropped and x0 never forwards.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_writeback_if.master  bus
);

    wb_req_t           req_a;
    wb_req_t           req_b;
    wb_req_t           sel;
    wb_src_e           src;
    logic [1:0]        grant;
    logic              wr_en;
    logic              wb_we_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [XLEN-1:0]   wb_data_q;
    logic              q1_hit;
    logic              q2_hit;

    always_comb begin
        req_a = '{valid: bus.a_valid, addr: bus.a_addr, data: bus.a_data};
        req_b = '{valid: bus.b_valid, addr: bus.b_addr, data: bus.b_data};
    end

    wb_arbiter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (req_a.valid),
        .b_valid (req_b.valid),
        .grant_c (grant),
        .src_c   (src)
    );

    assign bus.a_ready = grant[0];
    assign bus.b_ready = grant[1];

    // Winning request and whether it actually commits
    always_comb begin
        sel   = '0;
        wr_en = 1'b0;
        case (src)
            WB_SRC_A: sel = req_a;
            WB_SRC_B: sel = req_b;
            default:  sel = '0;
        endcase
`ifdef WB_X0_FILTER_EN
        wr_en = (src != WB_SRC_NONE) && (sel.addr != '0);
`else
        wr_en = (src != WB_SRC_NONE);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q <= wr_en;
            if (src != WB_SRC_NONE) begin
                wb_addr_q <= sel.addr;
                wb_data_q <= sel.data;
            end
        end
    end

    assign bus.wb_we   = wb_we_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

    // Forwarding compare against the write stage
    always_comb begin
        q1_hit = wb_we_q && (wb_addr_q == bus.q1_addr);
        q2_hit = wb_we_q && (wb_addr_q == bus.q2_addr);
`ifdef WB_X0_FILTER_EN
        if (bus.q1_addr == '0) q1_hit = 1'b0;
        if (bus.q2_addr == '0) q2_hit = 1'b0;
`endif
    end

    assign bus.q1_hit  = q1_hit;
    assign bus.q2_hit  = q2_hit;
    assign bus.q1_data = q1_hit ? wb_data_q : '0;
    assign bus.q2_data = q2_hit ? wb_data_q : '0;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a behavioural 32x32 register array on the write port.
module tb_regfile_writeback;
    import wb_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    logic [XLEN-1:0] rf [32];

    regfile_writeback_if bus ();

    regfile_writeback #(
        .STARVE_MAX (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register array fed by the write port
    always @(posedge clk) begin
        if (bus.wb_we) rf[bus.wb_addr] <= bus.wb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst         = 1'b1;
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd3;
        bus.a_data  = 32'h0000_0033;
        bus.b_valid = 1'b0;
        bus.b_addr  = '0;
        bus.b_data  = '0;
        bus.q1_addr = 5'd3;
        bus.q2_addr = 5'd0;

        // Reset holds the write stage empty even with a request pending
        step();
        step();
        check("rst_wb_we", 32'(bus.wb_we), 32'd0);
        check("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        check("rst_wb_data", bus.wb_data, 32'd0);
        check("rst_q1_hit", 32'(bus.q1_hit), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 1'b0;
        check("post_rst_wb_we", 32'(bus.wb_we), 32'd1);
        check("post_rst_wb_addr", 32'(bus.wb_addr), 32'd3);

        // Single write with forwarding
        step();
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd5;
        bus.a_data  = 32'hDEAD_BEEF;
        bus.q1_addr = 5'd5;
        bus.q2_addr = 5'd6;
        step();
        bus.a_valid = 1'b0;
        check("single_wb_we", 32'(bus.wb_we), 32'd1);
        check("single_wb_addr", 32'(bus.wb_addr), 32'd5);
        check("single_q1_hit", 32'(bus.q1_hit), 32'd1);
        check("single_q1_data", bus.q1_data, 32'hDEAD_BEEF);
        check("single_q2_hit", 32'(bus.q2_hit), 32'd0);
        check("single_q2_data", bus.q2_data, 32'd0);
        step();
        check("single_rf_x5", rf[5], 32'hDEAD_BEEF);
        check("idle_wb_we", 32'(bus.wb_we), 32'd0);
        check("idle_wb_addr_hold", 32'(bus.wb_addr), 32'd5);
        check("idle_q1_hit", 32'(bus.q1_hit), 32'd0);

        // Both ports valid for 8 cycles: A,A,A,B,A,A,A,B
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd1;
        bus.a_data  = 32'h1111_1111;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd2;
        bus.b_data  = 32'h2222_2222;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("starve_a_ready_%0d", i), 32'(bus.a_ready), (i % 4 == 3) ? 32'd0 : 32'd1);
            check($sformatf("starve_b_ready_%0d", i), 32'(bus.b_ready), (i % 4 == 3) ? 32'd1 : 32'd0);
            step();
            check($sformatf("starve_wb_addr_%0d", i), 32'(bus.wb_addr), (i % 4 == 3) ? 32'd2 : 32'd1);
            check($sformatf("starve_wb_we_%0d", i), 32'(bus.wb_we), 32'd1);
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        step();
        check("starve_rf_x1", rf[1], 32'h1111_1111);
        check("starve_rf_x2", rf[2], 32'h2222_2222);

        // Same destination from both ports: A first, B lands last
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd7;
        bus.a_data  = 32'h0000_0001;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd7;
        bus.b_data  = 32'h0000_0002;
        #1;
        check("same_a_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 1'b0;
        check("same_first_data", bus.wb_data, 32'h0000_0001);
        #1;
        check("same_b_ready", 32'(bus.b_ready), 32'd1);
        step();
        bus.b_valid = 1'b0;
        check("same_second_data", bus.wb_data, 32'h0000_0002);
        check("same_rf_x7_mid", rf[7], 32'h0000_0001);
        step();
        check("same_rf_x7_end", rf[7], 32'h0000_0002);

        // Write to x0
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd0;
        bus.a_data  = 32'hFFFF_FFFF;
        bus.q1_addr = 5'd0;
        #1;
        check("x0_a_ready", 32'(bus.a_ready), 32'd1);
        step();
        bus.a_valid = 1'b0;
`ifdef WB_X0_FILTER_EN
        check("x0_wb_we", 32'(bus.wb_we), 32'd0);
        check("x0_q1_hit", 32'(bus.q1_hit), 32'd0);
        check("x0_q1_data", bus.q1_data, 32'd0);
        step();
        check("x0_rf", rf[0], 32'd0);
`else
        check("x0_wb_we", 32'(bus.wb_we), 32'd1);
        check("x0_q1_hit", 32'(bus.q1_hit), 32'd1);
        check("x0_q1_data", bus.q1_data, 32'hFFFF_FFFF);
        step();
        check("x0_rf", rf[0], 32'hFFFF_FFFF);
`endif

        // Reset during the write stage drops the in-flight write
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd9;
        bus.a_data  = 32'h0000_1234;
        bus.q1_addr = 5'd9;
        step();
        bus.a_valid = 1'b0;
        check("mid_wb_we_before", 32'(bus.wb_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_wb_we_after", 32'(bus.wb_we), 32'd0);
        check("mid_wb_addr_after", 32'(bus.wb_addr), 32'd0);
        check("mid_q1_hit_after", 32'(bus.q1_hit), 32'd0);
        step();
        check("mid_rf_x9", rf[9], 32'd0);
        rst = 1'b0;

        // Reset clears the starvation counter
        bus.a_valid = 1'b1;
        bus.a_addr  = 5'd10;
        bus.b_valid = 1'b1;
        bus.b_addr  = 5'd11;
        step();
        step();
        step();
        check("cnt_b_forced", 32'(bus.b_ready), 32'd1);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check("cnt_cleared_a_ready", 32'(bus.a_ready), 32'd1);
        check("cnt_cleared_b_ready", 32'(bus.b_ready), 32'd0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
